// File: rtl/controller_dd_multi.sv
// Delay-difference PUF controller: reset/race/capture sequencing repeated n times,
// per-bit majority resolution and an unstable-bit mask.
module controller_dd_multi #(
  parameter int unsigned PUF_W   = 128,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned EV_W    = 4,
  parameter int unsigned RST_CYC = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [7:0]       CODE,
  input  logic [CNT_W-1:0] CNT_VAL,
  input  logic [EV_W-1:0]  N_EVAL,
  input  logic [PUF_W-1:0] PUF_OUT,
  output logic             RESET_DD,
  output logic             START_DD,
  output logic             BUSY,
  output logic             DONE,
  output logic [EV_W-1:0]  EVAL_IDX,
  output logic [PUF_W-1:0] PUF_OUT_REG,
  output logic [PUF_W-1:0] UNSTABLE_MASK
);

  localparam logic [7:0] CODE_SINGLE = 8'd1;
  localparam logic [7:0] CODE_MAJ    = 8'd2;
  localparam logic [7:0] CODE_ABORT  = 8'd3;
  localparam logic [7:0] CODE_CLEAR  = 8'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_EVAL,
    S_CAP,
    S_RES,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   ph_cnt_q, ph_cnt_d;
  logic [CNT_W-1:0]   cnt_lim_q, cnt_lim_d;
  logic [EV_W-1:0]    n_q, n_d;
  logic [EV_W-1:0]    idx_q, idx_d;
  logic [EV_W-1:0]    ones_q [PUF_W];
  logic [EV_W-1:0]    ones_d [PUF_W];
  logic [PUF_W-1:0]   ref_q, ref_d;
  logic [PUF_W-1:0]   macc_q, macc_d;
  logic [PUF_W-1:0]   res_q, res_d;
  logic [PUF_W-1:0]   umask_q, umask_d;
  logic               reset_dd_q, reset_dd_d;
  logic               start_dd_q, start_dd_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               busy_st;

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      ph_cnt_q   <= '0;
      cnt_lim_q  <= '0;
      n_q        <= '0;
      idx_q      <= '0;
      ref_q      <= '0;
      macc_q     <= '0;
      res_q      <= '0;
      umask_q    <= '0;
      reset_dd_q <= 1'b0;
      start_dd_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < int'(PUF_W); i++) ones_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ph_cnt_q   <= ph_cnt_d;
      cnt_lim_q  <= cnt_lim_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      ref_q      <= ref_d;
      macc_q     <= macc_d;
      res_q      <= res_d;
      umask_q    <= umask_d;
      reset_dd_q <= reset_dd_d;
      start_dd_q <= start_dd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      for (int i = 0; i < int'(PUF_W); i++) ones_q[i] <= ones_d[i];
    end
  end

  // Next-state, vote accumulation and output decode
  always_comb begin
    state_d    = state_q;
    ph_cnt_d   = ph_cnt_q;
    cnt_lim_d  = cnt_lim_q;
    n_d        = n_q;
    idx_d      = idx_q;
    ref_d      = ref_q;
    macc_d     = macc_q;
    res_d      = res_q;
    umask_d    = umask_q;
    reset_dd_d = 1'b0;
    start_dd_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    for (int i = 0; i < int'(PUF_W); i++) ones_d[i] = ones_q[i];

    busy_st = (state_q == S_RST) || (state_q == S_EVAL) ||
              (state_q == S_CAP) || (state_q == S_RES);

    if (busy_st && (CODE == CODE_ABORT)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if ((CODE == CODE_SINGLE) || (CODE == CODE_MAJ)) begin
            state_d   = S_RST;
            ph_cnt_d  = '0;
            cnt_lim_d = (CNT_VAL == '0) ? CNT_W'(1) : CNT_VAL;
            n_d       = ((CODE == CODE_SINGLE) || (N_EVAL == '0)) ? EV_W'(1) : N_EVAL;
            idx_d     = '0;
            macc_d    = '0;
            for (int i = 0; i < int'(PUF_W); i++) ones_d[i] = '0;
          end
        end
        S_RST: begin
          if (ph_cnt_q == CNT_W'(RST_CYC - 1)) begin
            state_d  = S_EVAL;
            ph_cnt_d = '0;
          end else begin
            ph_cnt_d = ph_cnt_q + CNT_W'(1);
          end
        end
        S_EVAL: begin
          if (ph_cnt_q == (cnt_lim_q - CNT_W'(1))) begin
            state_d  = S_CAP;
            ph_cnt_d = '0;
          end else begin
            ph_cnt_d = ph_cnt_q + CNT_W'(1);
          end
        end
        S_CAP: begin
          for (int i = 0; i < int'(PUF_W); i++) ones_d[i] = ones_q[i] + EV_W'(PUF_OUT[i]);
          // First capture becomes the reference every later one is compared to
          if (idx_q == '0) ref_d = PUF_OUT;
          else             macc_d = macc_q | (PUF_OUT ^ ref_q);
          if (idx_q < (n_q - EV_W'(1))) begin
            idx_d   = idx_q + EV_W'(1);
            state_d = S_RST;
          end else begin
            state_d = S_RES;
          end
        end
        S_RES: begin
          // Strict majority; a tie on even n resolves to 0
          for (int i = 0; i < int'(PUF_W); i++)
            res_d[i] = {ones_q[i], 1'b0} > {1'b0, n_q};
          umask_d = macc_q;
          state_d = S_DONE;
        end
        S_DONE: begin
          if (CODE == CODE_CLEAR) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Strobes follow the current state one cycle later; leaving to IDLE drops them at once
    if (state_d != S_IDLE) begin
      reset_dd_d = (state_q == S_RST);
      start_dd_d = (state_q == S_EVAL) || (state_q == S_CAP);
      busy_d     = busy_st;
      done_d     = (state_q == S_DONE);
    end
  end

  assign RESET_DD      = reset_dd_q;
  assign START_DD      = start_dd_q;
  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign EVAL_IDX      = idx_q;
  assign PUF_OUT_REG   = res_q;
  assign UNSTABLE_MASK = umask_q;

endmodule
